// File: rtl/alu_modport.sv
// alu_modport: registered 8-bit ALU, 16 opcodes, one-cycle latency
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-low reset, clears result and carry_out
//   a, b       8-bit unsigned operands
//   selection  4-bit opcode
//   result     registered 8-bit result
//   carry_out  registered carry / borrow / flag bit
module alu_modport (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] selection,
  output logic [7:0] result,
  output logic       carry_out
);
  logic [8:0]  sum;
  logic [8:0]  diff;
  logic [15:0] prod;
  logic [7:0]  quot;
  logic [7:0]  r_next;
  logic        c_next;
  assign sum  = {1'b0, a} + {1'b0, b};
  // bit 8 of the 9-bit difference is the borrow (a < b)
  assign diff = {1'b0, a} - {1'b0, b};
  assign prod = a * b;
  // divide-by-zero yields all ones; the flag is raised separately below
  assign quot = (b == 8'd0) ? 8'hFF : a / b;
  always_comb begin
    r_next = 8'h00;
    c_next = 1'b0;
    case (selection)
      4'h0: {c_next, r_next} = sum;
      4'h1: {c_next, r_next} = diff;
      4'h2: begin
        r_next = prod[7:0];
        c_next = |prod[15:8];
      end
      4'h3: begin
        r_next = quot;
        c_next = (b == 8'd0);
      end
      4'h4: {c_next, r_next} = {a, 1'b0};
      4'h5: {r_next, c_next} = {1'b0, a};
      4'h6: begin
        r_next = {a[6:0], a[7]};
        c_next = a[7];
      end
      4'h7: begin
        r_next = {a[0], a[7:1]};
        c_next = a[0];
      end
      4'h8: r_next = a & b;
      4'h9: r_next = a | b;
      4'hA: r_next = a ^ b;
      4'hB: r_next = ~(a | b);
      4'hC: r_next = ~(a & b);
      4'hD: r_next = ~(a ^ b);
      4'hE: r_next = {7'd0, a > b};
      4'hF: r_next = {7'd0, a == b};
      default: r_next = 8'h00;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      result    <= 8'h00;
      carry_out <= 1'b0;
    end else begin
      result    <= r_next;
      carry_out <= c_next;
    end
  end
endmodule

// File: tb/tb_alu_modport.sv
// tb_alu_modport: scoreboard bench for alu_modport with directed vectors
module tb_alu_modport;
  logic       clock;
  logic       reset;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] selection;
  logic [7:0] result;
  logic       carry_out;

  typedef struct {
    string      name;
    logic [7:0] r;
    logic       c;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  alu_modport dut (
    .clock(clock),
    .reset(reset),
    .a(a),
    .b(b),
    .selection(selection),
    .result(result),
    .carry_out(carry_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [7:0] gr, input logic gc,
                     input logic [7:0] er, input logic ec);
    checks++;
    if (gr !== er || gc !== ec) begin
      errors++;
      $display("FAIL %s: got result=%h carry=%b, expected result=%h carry=%b",
               name, gr, gc, er, ec);
    end
  endtask

  task automatic issue(input string name, input logic [7:0] ia, input logic [7:0] ib,
                       input logic [3:0] is, input logic [7:0] er, input logic ec);
    exp_t e;
    @(negedge clock);
    a = ia;
    b = ib;
    selection = is;
    e.name = name;
    e.r = er;
    e.c = ec;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clock);
      n++;
    end
    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses never checked", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk(e.name, result, carry_out, e.r, e.c);
      end
    end
  end

  initial begin
    reset = 1'b1;
    a = 8'h01;
    b = 8'h01;
    selection = 4'h0;
    #2 reset = 1'b0;
    #1 chk("reset_async", result, carry_out, 8'h00, 1'b0);
    #4 chk("reset_hold", result, carry_out, 8'h00, 1'b0);
    #1 reset = 1'b1;

    issue("add_ovf",   8'hFF, 8'h01, 4'h0, 8'h00, 1'b1);
    issue("sub_borrow",8'h10, 8'h20, 4'h1, 8'hF0, 1'b1);
    issue("sub_plain", 8'h20, 8'h10, 4'h1, 8'h10, 1'b0);
    issue("mul_ovf",   8'h10, 8'h10, 4'h2, 8'h00, 1'b1);
    issue("mul_plain", 8'h0F, 8'h03, 4'h2, 8'h2D, 1'b0);
    issue("div_plain", 8'h64, 8'h07, 4'h3, 8'h0E, 1'b0);
    issue("div_zero",  8'h64, 8'h00, 4'h3, 8'hFF, 1'b1);
    issue("shl",       8'h81, 8'h00, 4'h4, 8'h02, 1'b1);
    issue("shr",       8'h81, 8'h00, 4'h5, 8'h40, 1'b1);
    issue("rol",       8'h81, 8'h00, 4'h6, 8'h03, 1'b1);
    issue("ror",       8'h81, 8'h00, 4'h7, 8'hC0, 1'b1);
    issue("and",       8'hF0, 8'h3C, 4'h8, 8'h30, 1'b0);
    issue("or",        8'hF0, 8'h3C, 4'h9, 8'hFC, 1'b0);
    issue("xor",       8'hF0, 8'h3C, 4'hA, 8'hCC, 1'b0);
    issue("nor",       8'hF0, 8'h3C, 4'hB, 8'h03, 1'b0);
    issue("nand",      8'hF0, 8'h3C, 4'hC, 8'hCF, 1'b0);
    issue("xnor",      8'hF0, 8'h3C, 4'hD, 8'h33, 1'b0);
    issue("gt",        8'hF0, 8'h3C, 4'hE, 8'h01, 1'b0);
    issue("eq",        8'hF0, 8'h3C, 4'hF, 8'h00, 1'b0);

    issue("b2b_0", 8'h3A, 8'h4C, 4'h0, 8'h86, 1'b0);
    issue("b2b_1", 8'h05, 8'h03, 4'h1, 8'h02, 1'b0);
    issue("b2b_2", 8'h0C, 8'h15, 4'h2, 8'hFC, 1'b0);
    issue("b2b_3", 8'hC8, 8'h0A, 4'h3, 8'h14, 1'b0);
    issue("b2b_4", 8'h7F, 8'hA5, 4'h4, 8'hFE, 1'b0);
    issue("b2b_5", 8'h7E, 8'h5A, 4'h5, 8'h3F, 1'b0);
    issue("b2b_6", 8'h40, 8'hFF, 4'h6, 8'h80, 1'b0);
    issue("b2b_7", 8'h02, 8'h11, 4'h7, 8'h01, 1'b0);
    issue("b2b_8", 8'hAA, 8'h0F, 4'h8, 8'h0A, 1'b0);
    issue("b2b_9", 8'hA0, 8'h05, 4'h9, 8'hA5, 1'b0);
    issue("b2b_a", 8'hFF, 8'h0F, 4'hA, 8'hF0, 1'b0);
    issue("b2b_b", 8'h00, 8'h00, 4'hB, 8'hFF, 1'b0);
    issue("b2b_c", 8'hFF, 8'hFF, 4'hC, 8'h00, 1'b0);
    issue("b2b_d", 8'h12, 8'h12, 4'hD, 8'hFF, 1'b0);
    issue("b2b_e", 8'h10, 8'h20, 4'hE, 8'h00, 1'b0);
    issue("b2b_f", 8'h77, 8'h77, 4'hF, 8'h01, 1'b0);
    drain();

    @(negedge clock);
    a = 8'h55;
    b = 8'h33;
    selection = 4'h0;
    @(posedge clock);
    #1 chk("pre_reset", result, carry_out, 8'h88, 1'b0);
    #1 reset = 1'b0;
    #1 chk("reset_pulse", result, carry_out, 8'h00, 1'b0);
    #1 reset = 1'b1;
    begin
      exp_t e;
      e.name = "post_reset";
      e.r = 8'h88;
      e.c = 1'b0;
      sb.push_back(e);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
